// File: rtl/serial_adder_seq_if.sv
// Start/done handshake and operand/result bus for the bit-serial adder.
// The master drives start and the operands. The slave returns busy, done and the held result.
interface serial_adder_seq_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (output start, a, b, c_in, input busy, done, sum, c_out);
  modport slave  (input start, a, b, c_in, output busy, done, sum, c_out);
endinterface

// File: rtl/serial_adder_seq.sv
// LSB-first bit-serial adder: one full-adder slice per cycle, done pulses WIDTH+1 edges after start.
// start is ignored while busy. The result is held until the completion edge of the next operation.
module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_adder_seq_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, psum_q, psum_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             slice_s, slice_c;
  logic [WIDTH-1:0] psum_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    slice_s = a_q[0] ^ b_q[0] ^ carry_q;
    slice_c = (a_q[0] & b_q[0]) | ((a_q[0] ^ b_q[0]) & carry_q);
    // Shift/insert form keeps WIDTH=1 legal (no reversed part-selects).
    psum_shift            = psum_q >> 1;
    psum_shift[WIDTH-1]   = slice_s;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.c_in;
          psum_d  = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = slice_c;
        psum_d  = psum_shift;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          sum_d   = psum_shift;
          cout_d  = slice_c;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy  = (state_q == S_SHIFT);
  assign bus.done  = (state_q == S_DONE);
  assign bus.sum   = sum_q;
  assign bus.c_out = cout_q;
endmodule

// File: tb/tb_serial_adder_seq.sv
// Bench for serial_adder_seq: WIDTH=8 directed/random plus exhaustive WIDTH=4 and WIDTH=1 instances.
// The expected result is a plain integer add; latency and hold behaviour are checked cycle by cycle.
module tb_serial_adder_seq;
  logic clk;
  logic rst_n;

  serial_adder_seq_if #(.WIDTH(8)) if8 ();
  serial_adder_seq_if #(.WIDTH(4)) if4 ();
  serial_adder_seq_if #(.WIDTH(1)) if1 ();

  serial_adder_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_adder_seq #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  serial_adder_seq #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  int          sel;
  logic        op_start;
  logic [63:0] op_a, op_b;
  logic        op_c;

  assign if8.start = op_start && (sel == 0);
  assign if4.start = op_start && (sel == 1);
  assign if1.start = op_start && (sel == 2);
  assign if8.a = op_a[7:0];
  assign if8.b = op_b[7:0];
  assign if8.c_in = op_c;
  assign if4.a = op_a[3:0];
  assign if4.b = op_b[3:0];
  assign if4.c_in = op_c;
  assign if1.a = op_a[0:0];
  assign if1.b = op_b[0:0];
  assign if1.c_in = op_c;

  logic        obs_busy, obs_done;
  logic [64:0] obs_res;

  always_comb begin
    obs_busy = 1'b0;
    obs_done = 1'b0;
    obs_res  = '0;
    case (sel)
      0: begin obs_busy = if8.busy; obs_done = if8.done; obs_res = {56'd0, if8.c_out, if8.sum}; end
      1: begin obs_busy = if4.busy; obs_done = if4.done; obs_res = {60'd0, if4.c_out, if4.sum}; end
      2: begin obs_busy = if1.busy; obs_done = if1.done; obs_res = {63'd0, if1.c_out, if1.sum}; end
      default: ;
    endcase
  end

  int          total, bad;
  logic [64:0] prev_res [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (sel=%0d t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  function automatic logic [64:0] ref_add(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic c);
    logic [64:0] mask;
    mask = (65'd1 << w) - 65'd1;
    return ({1'b0, a} & mask) + ({1'b0, b} & mask) + {64'd0, c};
  endfunction

  function automatic int width_of(input int s);
    return (s == 0) ? 8 : (s == 1) ? 4 : 1;
  endfunction

  // Called at a negedge with the DUT in IDLE or DONE; returns at the negedge after the accepting edge.
  task automatic launch(input logic [63:0] a, input logic [63:0] b, input logic c);
    op_a = a;
    op_b = b;
    op_c = c;
    op_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_start = 1'b0;
    op_a = {$urandom, $urandom};
    op_b = {$urandom, $urandom};
    op_c = 1'($urandom);
  endtask

  task automatic finish_op(input logic [64:0] exp, input bit interfere);
    int w;
    int n;
    bit seen;
    w = width_of(sel);
    n = 1;
    seen = 1'b0;
    while (!seen && n <= w + 6) begin
      if (obs_done) begin
        seen = 1'b1;
      end else begin
        chk("busy_during_op", {64'd0, obs_busy}, {64'd0, (n <= w)});
        chk("result_held", obs_res, prev_res[sel]);
        if (interfere && n == 3) begin
          op_start = 1'b1;
          op_a = 64'h11;
          op_b = 64'h22;
        end
        if (interfere && n == 4) op_start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n++;
      end
    end
    chk("done_latency", 65'(n), 65'(w + 1));
    chk("result", obs_res, exp);
    chk("busy_in_done", {64'd0, obs_busy}, 65'd0);
    prev_res[sel] = exp;
  endtask

  task automatic idle_check();
    @(posedge clk);
    @(negedge clk);
    chk("done_single_pulse", {64'd0, obs_done}, 65'd0);
    chk("busy_idle", {64'd0, obs_busy}, 65'd0);
    chk("result_idle_hold", obs_res, prev_res[sel]);
  endtask

  task automatic run_one(input logic [63:0] a, input logic [63:0] b, input logic c);
    launch(a, b, c);
    finish_op(ref_add(width_of(sel), a, b, c), 1'b0);
    idle_check();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad = 0;
    for (int i = 0; i < 3; i++) prev_res[i] = '0;
    sel = 0;
    op_start = 1'b0;
    op_a = '0;
    op_b = '0;
    op_c = 1'b0;
    rst_n = 1'b0;
    #3;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("reset_busy", {64'd0, obs_busy}, 65'd0);
      chk("reset_done", {64'd0, obs_done}, 65'd0);
      chk("reset_result", obs_res, 65'd0);
    end
    sel = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed WIDTH=8 cases.
    run_one(64'h5A, 64'h3C, 1'b0);
    run_one(64'hFF, 64'h01, 1'b0);
    run_one(64'hFF, 64'hFF, 1'b1);
    launch(64'h5A, 64'h3C, 1'b0);
    finish_op(65'h096, 1'b1);
    // start held through DONE: the next operation begins with no IDLE gap.
    launch(64'h01, 64'h02, 1'b1);
    finish_op(65'h004, 1'b0);
    idle_check();

    for (int i = 0; i < 24; i++) begin
      logic [63:0] ra, rb;
      logic        rc;
      ra = 64'($urandom_range(0, 255));
      rb = 64'($urandom_range(0, 255));
      rc = 1'($urandom);
      launch(ra, rb, rc);
      finish_op(ref_add(8, ra, rb, rc), 1'b0);
      if ($urandom_range(0, 1) == 0) idle_check();
    end
    idle_check();

    sel = 1;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          run_one(64'(a), 64'(b), 1'(c));

    sel = 2;
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < 2; c++)
          run_one(64'(a), 64'(b), 1'(c));

    // Asynchronous reset between edges in the 4th SHIFT cycle.
    sel = 0;
    launch(64'h5A, 64'h3C, 1'b0);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("busy_before_abort", {64'd0, obs_busy}, 65'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {64'd0, obs_busy}, 65'd0);
    chk("abort_done", {64'd0, obs_done}, 65'd0);
    chk("abort_result", obs_res, 65'd0);
    for (int i = 0; i < 3; i++) prev_res[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) idle_check();
    run_one(64'h80, 64'h80, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
